// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between the in-order
// pipeline writeback (A, never stalls) and a multi-cycle unit (B, valid/ready).
// A always wins; B results wait in a small FIFO and drain when A is idle.
// A starvation counter requests a pipeline stall when the FIFO sits undrained.
// Optional feature: define RF_WB_FORWARD_EN to add Fwd1/Fwd2 forwarding outputs.
module regfile_wb_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        A_Valid,
  input  logic [4:0]  A_Reg,
  input  logic [31:0] A_Data,
  input  logic        B_Valid,
  output logic        B_Ready,
  input  logic [4:0]  B_Reg,
  input  logic [31:0] B_Data,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  output logic        Hazard1,
  output logic        Hazard2,
`ifdef RF_WB_FORWARD_EN
  output logic        Fwd1Valid,
  output logic        Fwd2Valid,
  output logic [31:0] Fwd1Data,
  output logic [31:0] Fwd2Data,
`endif
  output logic        Stall
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

  logic [PtrW-1:0]       rdPtr, wrPtr;
  logic [CntW-1:0]       fifoCount;
  logic [FIFO_DEPTH-1:0] entryValid;
  logic [4:0]            fifoReg  [FIFO_DEPTH];
  logic [31:0]           fifoData [FIFO_DEPTH];
  logic [StW-1:0]        starveCnt;

  logic full, empty, bAccept, bKeep, push, pop, starveInc, stallNext;
  logic hit1, hit2;

  // Handshake, push/pop decisions and next stall request.
  always_comb begin
    full      = (fifoCount == CntW'(FIFO_DEPTH));
    empty     = (fifoCount == '0);
    B_Ready   = !full;
    bAccept   = B_Valid && !full;
    // R0 writes complete the handshake but are never stored.
    bKeep     = bAccept && (B_Reg != 5'd0);
    pop       = !A_Valid && !empty;
    // B bypasses the FIFO only when A is idle and nothing is queued.
    push      = bKeep && (A_Valid || !empty);
    starveInc = !empty && !pop;
    stallNext = ((starveCnt >= StW'(STARVE_LIMIT - 1)) && starveInc) ||
                ((starveCnt == StW'(STARVE_LIMIT)) && !pop);
  end

  // FIFO pointers, occupancy and per-entry valid bits.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      fifoCount  <= '0;
      entryValid <= '0;
    end else begin
      if (push) begin
        entryValid[wrPtr] <= 1'b1;
        wrPtr             <= wrPtr + PtrW'(1);
      end
      if (pop) begin
        entryValid[rdPtr] <= 1'b0;
        rdPtr             <= rdPtr + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifoCount <= fifoCount + CntW'(1);
        2'b01:   fifoCount <= fifoCount - CntW'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  // FIFO storage; contents are qualified by entryValid so no reset is needed.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifoReg[wrPtr]  <= B_Reg;
      fifoData[wrPtr] <= B_Data;
    end
  end

  // Registered write-port output stage: A, then FIFO head, then bypassed B.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      RegWrite      <= 1'b0;
      WriteRegister <= 5'd0;
      WriteData     <= 32'd0;
    end else if (A_Valid) begin
      RegWrite      <= (A_Reg != 5'd0);
      WriteRegister <= A_Reg;
      WriteData     <= A_Data;
    end else if (!empty) begin
      RegWrite      <= 1'b1;
      WriteRegister <= fifoReg[rdPtr];
      WriteData     <= fifoData[rdPtr];
    end else if (bKeep) begin
      RegWrite      <= 1'b1;
      WriteRegister <= B_Reg;
      WriteData     <= B_Data;
    end else begin
      RegWrite      <= 1'b0;
    end
  end

  // Starvation counter (saturating) and registered stall request.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      starveCnt <= '0;
      Stall     <= 1'b0;
    end else begin
      if (empty || pop) begin
        starveCnt <= '0;
      end else if (starveCnt != StW'(STARVE_LIMIT)) begin
        starveCnt <= starveCnt + StW'(1);
      end
      Stall <= stallNext;
    end
  end

  // Read-hazard flags: pending write in the FIFO or in the output stage.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (entryValid[i] && (fifoReg[i] == ReadRegister1)) hit1 = 1'b1;
      if (entryValid[i] && (fifoReg[i] == ReadRegister2)) hit2 = 1'b1;
    end
    Hazard1 = (ReadRegister1 != 5'd0) &&
              (hit1 || (RegWrite && (WriteRegister == ReadRegister1)));
    Hazard2 = (ReadRegister2 != 5'd0) &&
              (hit2 || (RegWrite && (WriteRegister == ReadRegister2)));
  end

`ifdef RF_WB_FORWARD_EN
  logic [PtrW-1:0] fwdIdx;

  // Youngest matching write: scan FIFO oldest to newest, output stage last.
  always_comb begin
    Fwd1Data = 32'd0;
    Fwd2Data = 32'd0;
    fwdIdx   = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      fwdIdx = rdPtr + PtrW'(i);
      if (entryValid[fwdIdx] && (fifoReg[fwdIdx] == ReadRegister1)) Fwd1Data = fifoData[fwdIdx];
      if (entryValid[fwdIdx] && (fifoReg[fwdIdx] == ReadRegister2)) Fwd2Data = fifoData[fwdIdx];
    end
    if (RegWrite && (WriteRegister == ReadRegister1)) Fwd1Data = WriteData;
    if (RegWrite && (WriteRegister == ReadRegister2)) Fwd2Data = WriteData;
    Fwd1Valid = Hazard1;
    Fwd2Valid = Hazard2;
  end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between two writeback sources: the in-order pipeline writeback (source A, cannot stall) and a multi-cycle unit such as mult/div (source B, valid/ready). A always wins the port; B results queue in a small FIFO and drain in cycles where A is idle. A starvation counter raises a pipeline stall request, and pending-destination tracking drives read-hazard flags toward hazard detection.

## Interface
- FIFO_DEPTH, 2: source-B holding FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 8: consecutive cycles a non-empty FIFO may go undrained before Stall asserts
- Clk  in  1  clock, rising-edge
- Rst  in  1  reset, asynchronous, active-high
- A_Valid  in  1  pipeline writeback request (never back-pressured)
- A_Reg  in  5  A destination register
- A_Data  in  32  A write data
- B_Valid  in  1  multi-cycle unit result valid
- B_Ready  out  1  FIFO can accept (= not full)
- B_Reg  in  5  B destination register
- B_Data  in  32  B write data
- RegWrite  out  1  register file write enable (registered)
- WriteRegister  out  5  register file write address (registered)
- WriteData  out  32  register file write data (registered)
- ReadRegister1, ReadRegister2  in  5 each  decode-stage read addresses
- Hazard1, Hazard2  out  1 each  read address has a pending write in FIFO or output stage
- Stall  out  1  pipeline freeze request (registered)

## Operation
- Rst clears FIFO (empty), starvation counter 0, RegWrite/WriteRegister/WriteData/Stall = 0; B_Ready = 1 after reset. Rst mid-operation discards all queued B results.
- B accepted on rising edge when B_Valid && B_Ready. B_Ready = !full, combinational from FIFO count; no push when full, even if a pop occurs that cycle.
- Port selection per edge: A_Valid → output stage loads A; else FIFO non-empty → pop head to output stage; else B accepted this edge and FIFO empty → B goes directly to output stage (bypasses FIFO); else RegWrite ← 0.
- With A_Valid high and B accepted, B is pushed; A goes out.
- Any write with destination 0 (A or B) is dropped: RegWrite ← 0 for A; B is accepted (handshake completes) but never enqueued.
- FIFO ordering is strict first-in-first-out; pointers wrap modulo FIFO_DEPTH.
- Starvation counter: increments each edge FIFO is non-empty and no pop occurs; clears on any pop or when empty; saturates at STARVE_LIMIT. Stall ← (counter ≥ STARVE_LIMIT−1 and increments this edge) or (counter = STARVE_LIMIT and no pop). Stall drops the edge after a pop. A still wins if A_Valid remains high during Stall.
- HazardN = ReadRegisterN ≠ 0 and (matches any valid FIFO entry's register, or RegWrite && WriteRegister matches). Combinational.

## Timing
- A_Valid sampled at edge n → RegWrite/WriteRegister/WriteData valid after edge n, register file commits at edge n+1.
- B with empty FIFO and idle A: same one-cycle latency as A.
- B queued: leaves on first edge with A_Valid low; worst case bounded only by Stall cooperation.
- Hazard outputs settle within the cycle from ReadRegister inputs and current state.

## Configuration
- RF_WB_FORWARD_EN defined: adds outputs Fwd1Valid/Fwd2Valid (1) and Fwd1Data/Fwd2Data (32); when HazardN is high, FwdNData is the youngest matching write (output stage newer than FIFO; newest FIFO entry wins among duplicates) and FwdNValid = 1. Hazard flags unchanged.
- Not defined: forwarding ports and match-priority logic absent; only Hazard flags exist.

## Test plan
- Reset: drive Rst mid-stream with 2 entries queued → all outputs 0, B_Ready = 1, queued entries never written after release.
- Idle port: B_Valid, B_Reg=5, B_Data=0x1234, A idle → next cycle RegWrite=1, WriteRegister=5, WriteData=0x1234; FIFO stays empty.
- Contention: A_Valid every cycle for 4 cycles, B pushes R7=0xA then R8=0xB → B_Ready=0 after second push; A writes appear in order; on first A-idle cycle R7=0xA written, next cycle R8=0xB.
- Starvation: A_Valid held high with one B entry queued, STARVE_LIMIT=8 → Stall rises after 8th undrained cycle; drop A_Valid → entry written, Stall clears next edge.
- R0 and hazards: A_Reg=0 → RegWrite stays 0; queued R9, ReadRegister1=9 → Hazard1=1; ReadRegister2=0 → Hazard2=0.
- Forwarding (RF_WB_FORWARD_EN): queued R3=0x11 then R3=0x22, ReadRegister1=3 → Fwd1Valid=1, Fwd1Data=0x22.
